ecc_error_logger: RTL and testbench



---
 rtl/ecc_error_logger_if.sv | 23 ++
 rtl/ecc_error_logger.sv | 148 ++++++++++++++
 tb/tb_ecc_error_logger.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_error_logger_if.sv
// Wishbone slave bundle between the management SoC and the ECC error logger.
// Carries cyc&stb, write enable, address, write data, ack and read data.
// The master drives the request and the slave returns a single-cycle ack.
interface ecc_error_logger_if #(
  parameter int WORD_SIZE = 32
);
  logic                 valid_i;
  logic                 wbs_we_i;
  logic [31:0]          wbs_adr_i;
  logic [WORD_SIZE-1:0] wdata_i;
  logic                 ready_o;
  logic [WORD_SIZE-1:0] rdata_o;

  modport master (
    output valid_i, wbs_we_i, wbs_adr_i, wdata_i,
    input  ready_o, rdata_o
  );

  modport slave (
    input  valid_i, wbs_we_i, wbs_adr_i, wdata_i,
    output ready_o, rdata_o
  );
endinterface

// File: rtl/ecc_error_logger.sv
// Counts corrected/uncorrectable ECC events, logs records in a small FIFO, raises irq.
// Wishbone access: ack and registered read data one cycle after the hit cycle.
// No backpressure on events: a push into a full FIFO (without same-cycle pop) is dropped and flagged.
module ecc_error_logger #(
  parameter int          WORD_SIZE         = 32,
  parameter int          REGDIRSIZE        = 5,
  parameter int          VERIFICATION_PINS = 2,
  parameter int          COUNTERSIZE       = 32,
  parameter int          DEPTH             = 4,
  parameter logic [31:0] BASE_ADR          = 32'h3000_0100
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         result_valid_i,
  input  logic [VERIFICATION_PINS-1:0] operation_result_i,
  input  logic [WORD_SIZE-1:0]         store_data_i,
  input  logic [REGDIRSIZE-1:0]        register_i,
  ecc_error_logger_if.slave            wb,
  output logic                         irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [COUNTERSIZE-1:0] CNT_ONE = COUNTERSIZE'(1);

  // Register offsets within the decoded 256-byte window
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_CORR   = 8'h04;
  localparam logic [7:0] OFF_UNCORR = 8'h08;
  localparam logic [7:0] OFF_HDATA  = 8'h0C;
  localparam logic [7:0] OFF_HINFO  = 8'h10;
  localparam logic [7:0] OFF_POP    = 8'h14;
  localparam logic [7:0] OFF_CTRL   = 8'h18;

  logic [WORD_SIZE-1:0]   mem_data [DEPTH];
  logic [REGDIRSIZE-1:0]  mem_reg  [DEPTH];
  logic [1:0]             mem_type [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level, level_next;
  logic                   overflow, overflow_next;
  logic [1:0]             ctrl;
  logic [COUNTERSIZE-1:0] corr_cnt, uncorr_cnt, corr_next, uncorr_next;

  logic                   empty, full, hit, wr_hit, ctrl_wr, clr;
  logic                   ev_corr, ev_unc, push_req, push, pop, drop;
  logic [1:0]             ev_type;
  logic [7:0]             off;
  logic [WORD_SIZE-1:0]   rd_val;
  logic                   unused_wdata;

  assign unused_wdata = ^wb.wdata_i[30:2];

  assign off     = wb.wbs_adr_i[7:0];
  assign hit     = wb.valid_i & (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~wb.ready_o;
  assign wr_hit  = hit & wb.wbs_we_i;
  assign ctrl_wr = wr_hit & (off == OFF_CTRL);
  assign clr     = ctrl_wr & wb.wdata_i[31];

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Code 01 is corrected; any other nonzero code counts as uncorrectable.
  assign ev_corr  = result_valid_i & (operation_result_i == VERIFICATION_PINS'(1));
  assign ev_unc   = result_valid_i & (operation_result_i != '0) & ~ev_corr;
  assign ev_type  = ev_corr ? 2'b01 : 2'b10;
  assign push_req = (ev_corr & ctrl[0]) | (ev_unc & ctrl[1]);
  assign pop      = wr_hit & (off == OFF_POP) & ~empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Next-state for level, overflow and the saturating counters; clear wins over events.
  always_comb begin
    level_next    = level + LW'(push) - LW'(pop);
    overflow_next = clr ? 1'b0 : (overflow | drop);
    corr_next     = corr_cnt;
    uncorr_next   = uncorr_cnt;
    if (clr) begin
      corr_next   = ev_corr ? CNT_ONE : '0;
      uncorr_next = ev_unc  ? CNT_ONE : '0;
    end else begin
      if (ev_corr && !(&corr_cnt))  corr_next   = corr_cnt + CNT_ONE;
      if (ev_unc  && !(&uncorr_cnt)) uncorr_next = uncorr_cnt + CNT_ONE;
    end
  end

  // Register read mux on pre-update state.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: begin
        rd_val[0]       = empty;
        rd_val[1]       = full;
        rd_val[2]       = overflow;
        rd_val[3 +: LW] = level;
        rd_val[8]       = irq_o;
      end
      OFF_CORR:   rd_val[COUNTERSIZE-1:0] = corr_cnt;
      OFF_UNCORR: rd_val[COUNTERSIZE-1:0] = uncorr_cnt;
      OFF_HDATA:  if (!empty) rd_val = mem_data[rd_ptr];
      OFF_HINFO: begin
        if (!empty) begin
          rd_val[1:0]             = mem_type[rd_ptr];
          rd_val[8 +: REGDIRSIZE] = mem_reg[rd_ptr];
        end
      end
      OFF_CTRL:   rd_val[1:0] = ctrl;
      default:    rd_val = '0;
    endcase
  end

  // Record storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= store_data_i;
      mem_reg[wr_ptr]  <= register_i;
      mem_type[wr_ptr] <= ev_type;
    end
  end

  // State, Wishbone ack/read data and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      ctrl       <= 2'b11;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      wb.ready_o <= 1'b0;
      wb.rdata_o <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level      <= level_next;
      overflow   <= overflow_next;
      corr_cnt   <= corr_next;
      uncorr_cnt <= uncorr_next;
      if (ctrl_wr) ctrl <= wb.wdata_i[1:0];
      wb.ready_o <= hit;
      wb.rdata_o <= (hit & ~wb.wbs_we_i) ? rd_val : '0;
      irq_o      <= (level_next != '0) | overflow_next;
    end
  end

endmodule

// File: tb/tb_ecc_error_logger.sv
// Directed bench for ecc_error_logger with a scoreboard of expected Wishbone read data.
// Stimulus pushes the expected ack data into a queue; a monitor pops and compares on every ack.
// Counters are built 4 bits wide so saturation is reachable with a short event flood.
module tb_ecc_error_logger;
  localparam logic [31:0] A = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        result_valid = 1'b0;
  logic [1:0]  op_result = 2'b00;
  logic [31:0] store_data = '0;
  logic [4:0]  reg_idx = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  ecc_error_logger_if #(.WORD_SIZE(32)) wb ();

  ecc_error_logger #(
    .WORD_SIZE(32), .REGDIRSIZE(5), .VERIFICATION_PINS(2),
    .COUNTERSIZE(4), .DEPTH(4), .BASE_ADR(A)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .result_valid_i(result_valid),
    .operation_result_i(op_result),
    .store_data_i(store_data),
    .register_i(reg_idx),
    .wb(wb.slave),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb.ready_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        chk(name_q.pop_front(), wb.rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] wdata,
                         input logic [31:0] exp, input string name,
                         input logic ev_en, input logic [1:0] code,
                         input logic [4:0] ridx, input logic [31:0] sdata);
    int lat;
    exp_q.push_back(we ? 32'h0 : exp);
    name_q.push_back(name);
    @(negedge clk);
    wb.valid_i   = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = A | {24'h0, off};
    wb.wdata_i   = wdata;
    if (ev_en) begin
      result_valid = 1'b1;
      op_result    = code;
      reg_idx      = ridx;
      store_data   = sdata;
    end
    @(negedge clk);
    result_valid = 1'b0;
    op_result    = 2'b00;
    lat = 1;
    while (wb.ready_o !== 1'b1 && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    if (wb.ready_o !== 1'b1) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    wb.valid_i  = 1'b0;
    wb.wbs_we_i = 1'b0;
    chk({name, "_ack_latency"}, lat, 1);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, off, 32'h0, exp, name, 1'b0, 2'b00, 5'd0, 32'h0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wdata, input string name);
    wb_xfer(1'b1, off, wdata, 32'h0, name, 1'b0, 2'b00, 5'd0, 32'h0);
  endtask

  task automatic ev(input logic [1:0] code, input logic [4:0] ridx, input logic [31:0] sdata);
    @(negedge clk);
    result_valid = 1'b1;
    op_result    = code;
    reg_idx      = ridx;
    store_data   = sdata;
    @(negedge clk);
    result_valid = 1'b0;
    op_result    = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.valid_i   = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wdata_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {31'h0, wb.ready_o}, 32'h0);
    chk("rst_rdata", wb.rdata_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd(8'h00, 32'h1, "rst_status");
    rd(8'h18, 32'h3, "rst_ctrl");

    // Single corrected event, inspect, pop
    ev(2'b01, 5'd5, 32'hDEADBEEF);
    chk("irq_after_push", {31'h0, irq}, 32'h1);
    rd(8'h04, 32'h1, "corr_cnt_1");
    rd(8'h00, 32'h108, "status_level1");
    rd(8'h0C, 32'hDEADBEEF, "head_data");
    rd(8'h10, 32'h0501, "head_info");
    wr(8'h14, 32'h0, "pop_1");
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    rd(8'h00, 32'h1, "status_after_pop");
    rd(8'h0C, 32'h0, "head_data_empty");

    // Five uncorrectable events, never popped: fifth is dropped
    for (int i = 1; i <= 5; i++) ev(2'b10, 5'(i), 32'h1000 + i);
    rd(8'h08, 32'h5, "uncorr_cnt_5");
    rd(8'h00, 32'h126, "status_full_ovf");
    rd(8'h0C, 32'h1001, "head_first_rec");
    rd(8'h10, 32'h0102, "head_info_first");
    rd(8'h1C, 32'h0, "unmapped_read");

    // Clear counters and overflow; FIFO contents remain
    wr(8'h18, 32'h8000_0003, "clear");
    rd(8'h00, 32'h122, "status_after_clear");
    rd(8'h18, 32'h3, "ctrl_bit31_reads0");

    // Full FIFO: pop and push in the same cycle
    wb_xfer(1'b1, 8'h14, 32'h0, 32'h0, "pop_push", 1'b1, 2'b10, 5'd9, 32'hCAFE0009);
    rd(8'h00, 32'h122, "status_pop_push");
    rd(8'h08, 32'h1, "uncorr_after_pop_push");
    wr(8'h14, 32'h0, "pop_a");
    rd(8'h0C, 32'h1003, "head_after_pop_a");
    wr(8'h14, 32'h0, "pop_b");
    wr(8'h14, 32'h0, "pop_c");
    rd(8'h0C, 32'hCAFE0009, "tail_rec_data");
    rd(8'h10, 32'h0902, "tail_rec_info");
    wr(8'h14, 32'h0, "pop_d");
    wr(8'h14, 32'h0, "pop_empty");
    rd(8'h00, 32'h1, "status_drained");
    chk("irq_drained", {31'h0, irq}, 32'h0);

    // Enable filtering: only corrected records are logged
    wr(8'h18, 32'h8000_0001, "ctrl_corr_only");
    ev(2'b10, 5'd3, 32'h3333);
    rd(8'h08, 32'h1, "uncorr_filtered");
    rd(8'h00, 32'h1, "status_filtered");
    ev(2'b11, 5'd4, 32'h4444);
    rd(8'h08, 32'h2, "uncorr_code11");
    ev(2'b01, 5'd6, 32'h6666);
    ev(2'b00, 5'd7, 32'h7777);
    rd(8'h04, 32'h1, "corr_enabled");
    rd(8'h00, 32'h108, "status_corr_logged");
    rd(8'h08, 32'h2, "uncorr_code00_ignored");
    wr(8'h14, 32'h0, "pop_corr");

    // Saturation and clear-vs-event priority
    wr(8'h18, 32'h8000_0003, "clear_2");
    for (int i = 0; i < 16; i++) ev(2'b10, 5'd1, 32'h100 + i);
    rd(8'h08, 32'hF, "uncorr_saturated");
    rd(8'h00, 32'h126, "status_flood");
    wb_xfer(1'b1, 8'h18, 32'h8000_0003, 32'h0, "clear_with_event", 1'b1, 2'b10, 5'd2, 32'h2222);
    rd(8'h08, 32'h1, "uncorr_clear_event");
    rd(8'h04, 32'h0, "corr_clear_event");
    rd(8'h00, 32'h122, "status_clear_event");

    // Non-matching base address is never acked
    @(negedge clk);
    wb.valid_i   = 1'b1;
    wb.wbs_adr_i = 32'h3000_0200;
    repeat (3) @(negedge clk);
    chk("miss_no_ack", {31'h0, wb.ready_o}, 32'h0);
    wb.valid_i = 1'b0;

    // Reset arriving with a hit suppresses the ack and discards the FIFO
    @(negedge clk);
    wb.valid_i   = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = A;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ack_suppressed", {31'h0, wb.ready_o}, 32'h0);
    wb.valid_i = 1'b0;
    rst = 1'b0;
    chk("rst_irq_cleared", {31'h0, irq}, 32'h0);
    rd(8'h00, 32'h1, "status_after_rst");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
